// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between two burst sources.
// The winning source owns the port for len+1 words; FIFO back-pressure comes in on wrfull_i.
module fifo_write_arbiter #(
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          req0_i,
    input  logic [LW-1:0] len0_i,
    input  logic          valid0_i,
    input  logic [DW-1:0] data0_i,
    output logic          gnt0_o,
    output logic          ack0_o,
    input  logic          req1_i,
    input  logic [LW-1:0] len1_i,
    input  logic          valid1_i,
    input  logic [DW-1:0] data1_i,
    output logic          gnt1_o,
    output logic          ack1_o,
    input  logic          wrfull_i,
    output logic          wrreq_o,
    output logic [DW-1:0] data_o,
    output logic          busy_o,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]    state;
    logic          owner;
    logic          last_owner;
    logic [LW-1:0] cnt;
    logic          winner;
    logic          valid_sel;
    logic          wr_hs;

    // Handshake: a word moves only in BURST when the owner is valid and the FIFO is not full;
    // ack to the owner equals wrreq_o in that cycle, the other source never sees an ack.
    always_comb begin
        winner    = (req0_i && req1_i) ? ~last_owner : req1_i;
        valid_sel = owner ? valid1_i : valid0_i;
        wr_hs     = (state == ST_BURST) && valid_sel && !wrfull_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        owner <= winner;
                        cnt   <= winner ? len1_i : len0_i;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: state <= ST_BURST;
                ST_BURST: begin
                    if (wr_hs) begin
                        if (cnt == '0) state <= ST_GAP;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                default: begin
                    // Dead cycle lets the finished source drop req before re-arbitration.
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state == ST_GRANT) || (state == ST_BURST);
    assign gnt0_o      = busy_o && !owner;
    assign gnt1_o      = busy_o && owner;
    assign wrreq_o     = wr_hs;
    assign ack0_o      = wr_hs && !owner;
    assign ack1_o      = wr_hs && owner;
    assign data_o      = owner ? data1_i : data0_i;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter against a burst-level reference model.
module tb_fifo_write_arbiter;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          req0_i, req1_i, valid0_i, valid1_i, wrfull_i;
    logic [LW-1:0] len0_i, len1_i;
    logic [DW-1:0] data0_i, data1_i;
    logic          gnt0_o, gnt1_o, ack0_o, ack1_o, wrreq_o, busy_o;
    logic [DW-1:0] data_o;
    logic [1:0]    dbg_state_o;

    fifo_write_arbiter #(.DW(DW), .LW(LW)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .req0_i(req0_i), .len0_i(len0_i), .valid0_i(valid0_i), .data0_i(data0_i),
        .gnt0_o(gnt0_o), .ack0_o(ack0_o),
        .req1_i(req1_i), .len1_i(len1_i), .valid1_i(valid1_i), .data1_i(data1_i),
        .gnt1_o(gnt1_o), .ack1_o(ack1_o),
        .wrfull_i(wrfull_i), .wrreq_o(wrreq_o), .data_o(data_o), .busy_o(busy_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;
    int model_writes = 0;

    // reference model: which source owns the port and how many words of its burst remain
    int m_owner;
    int m_prev;
    int m_words;
    bit m_setup;
    bit m_gap;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_prev  = 1;
        m_words = 0;
        m_setup = 1'b0;
        m_gap   = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input bit r0, input bit r1, input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                         input bit v0, input bit v1, input bit full);
        req0_i = r0; req1_i = r1; len0_i = l0; len1_i = l1;
        valid0_i = v0; valid1_i = v1; wrfull_i = full;
        data0_i = $urandom; data1_i = $urandom;
    endtask

    // Called at the falling edge after inputs are driven: check, advance the model, move one cycle.
    task automatic step();
        bit in_burst, v_own, e_wr;
        logic [DW-1:0] d_own;
        #1;
        in_burst = (m_words > 0) && !m_setup;
        v_own    = (m_owner == 1) ? valid1_i : valid0_i;
        d_own    = (m_owner == 1) ? data1_i : data0_i;
        e_wr     = in_burst && v_own && !wrfull_i;
        check("wrreq", wrreq_o, e_wr);
        check("ack0", ack0_o, e_wr && m_owner == 0);
        check("ack1", ack1_o, e_wr && m_owner == 1);
        check("gnt0", gnt0_o, m_words > 0 && m_owner == 0);
        check("gnt1", gnt1_o, m_words > 0 && m_owner == 1);
        check("busy", busy_o, m_words > 0);
        if (e_wr) begin
            exp_q.push_back(d_own);
            model_writes++;
        end
        if (wrreq_o === 1'b1) begin
            dut_writes++;
            if (exp_q.size() == 0) check("unexpected_write", data_o, 'x);
            else check("data", data_o, exp_q.pop_front());
        end
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_words == 0) begin
            if (req0_i || req1_i) begin
                m_owner = (req0_i && req1_i) ? 1 - m_prev : (req1_i ? 1 : 0);
                m_prev  = m_owner;
                m_words = ((m_owner == 1) ? int'(len1_i) : int'(len0_i)) + 1;
                m_setup = 1'b1;
            end
        end else if (m_setup) begin
            m_setup = 1'b0;
        end else if (e_wr) begin
            m_words--;
            if (m_words == 0) m_gap = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n_i = 1'b0;
        drive(0, 0, '0, '0, 0, 0, 0);
        model_reset();
        #1;
        check("rst_wrreq", wrreq_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_gnt", {gnt1_o, gnt0_o}, 0);
        check("rst_ack", {ack1_o, ack0_o}, 0);
        check("rst_data", data_o, data0_i);
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;

        // single source, len 3
        for (int i = 0; i < 14; i++) begin
            drive(i < 2, 0, 8'd3, '0, 1, 0, 0);
            step();
        end
        // both requesting continuously, len 1
        for (int i = 0; i < 24; i++) begin
            drive(1, 1, 8'd1, 8'd1, 1, 1, 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 8'd1, 8'd1, 1, 1, 0);
            step();
        end
        // len 7 with wrfull stalls
        for (int i = 0; i < 32; i++) begin
            drive(i < 2, 0, 8'd7, '0, 1, 0, (i >= 4 && i <= 6) || ($urandom_range(0, 3) == 0));
            step();
        end
        // source 1 with toggling valid
        for (int i = 0; i < 14; i++) begin
            drive(0, i < 2, '0, 8'd3, 0, i[0] == 1'b0, 0);
            step();
        end
        // maximum burst; len changes after the grant must not matter
        for (int i = 0; i < 264; i++) begin
            drive(i < 2, 0, (i < 2) ? 8'hFF : LW'($urandom), '0, 1, 0, 0);
            step();
        end
        // fully random traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), LW'($urandom_range(0, 7)),
                  LW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0);
            step();
        end
        for (int i = 0; i < 24; i++) begin
            drive(0, 0, '0, '0, 1, 1, 0);
            step();
        end
        check("idle_after_drain", busy_o, 0);

        // reset in the middle of a 6-word burst after 2 words
        begin
            int budget = 0;
            drive(1, 0, 8'd5, '0, 1, 0, 0);
            while (!(m_words == 4 && !m_setup) && budget < 20) begin
                drive(1, 0, 8'd5, '0, 1, 0, 0);
                step();
                budget++;
            end
            check("reach_mid_burst", budget < 20, 1);
        end
        drive(1, 1, 8'd5, 8'd5, 1, 1, 0);
        #1;
        check("pre_rst_wrreq", wrreq_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("async_rst_wrreq", wrreq_o, 0);
        check("async_rst_gnt", {gnt1_o, gnt0_o}, 0);
        check("async_rst_busy", busy_o, 0);
        model_reset();
        @(negedge clk);
        reset_n_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, '0, '0, 1, 1, 0);
            step();
        end

        check("write_count", dut_writes, model_writes);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
